// File: rtl/aes_seq_pkg.sv
// Shared state encoding, block geometry and word slicing for the AES FIFO sequencer.
package aes_seq_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT,
    DRAIN
  } state_t;

  // Word 0 is the most significant word of the block.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [1:0]         idx);
    return blk[BLOCK_W-1-WORD_W*int'(idx) -: WORD_W];
  endfunction

endpackage

// File: rtl/aes_seq_word_unpack.sv
// Holds the AES result block and presents one 32-bit word of it, MSW at select 0.
module aes_seq_word_unpack
  import aes_seq_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic [BLOCK_W-1:0] din,
  input  logic [1:0]         sel,
  output logic [WORD_W-1:0]  dout
);

  logic [BLOCK_W-1:0] r_hold;
  logic [WORD_W-1:0]  w_words [WORDS_PER_BLOCK];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold <= '0;
    end else if (load) begin
      r_hold <= din;
    end
  end

  generate
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
      assign w_words[gi] = word_sel(r_hold, 2'(gi));
    end
  endgenerate

  assign dout = w_words[sel];

endmodule

// File: rtl/aes_fifo_sequencer.sv
// Packs four FIFO words into an AES block, runs the core, unpacks the result to the output FIFO.
// Optional WAIT watchdog is built only when SEQ_TIMEOUT_EN is defined.
module aes_fifo_sequencer #(
  parameter int WORD_W         = 32,
  parameter int BLOCK_W        = 128,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               in_empty,
  output logic               in_read,
  input  logic [WORD_W-1:0]  in_data,
  output logic [BLOCK_W-1:0] aes_block,
  output logic               aes_start,
  input  logic               aes_done,
  input  logic [BLOCK_W-1:0] aes_result,
  input  logic               out_full,
  output logic               out_write,
  output logic [WORD_W-1:0]  out_data,
  output logic               busy,
  output logic [CNT_W-1:0]   blocks_done,
  output logic               err_timeout
);
  import aes_seq_pkg::*;

  state_t             r_state;
  logic [2:0]         r_rd_cnt;
  logic [1:0]         r_cap_cnt;
  logic [1:0]         r_wr_cnt;
  logic               r_rd_d;
  logic [BLOCK_W-1:0] r_aes_block;
  logic               r_aes_start;
  logic [CNT_W-1:0]   r_blocks_done;
  logic               w_in_read;
  logic               w_out_write;
  logic               w_load;
  logic               w_timeout;

  // Strobes stay combinational so they can never fire against a flag that just changed.
  assign w_in_read   = (r_state == FETCH) && !in_empty && (r_rd_cnt < 3'(WORDS_PER_BLOCK));
  assign w_out_write = (r_state == DRAIN) && !out_full;
  assign w_load      = (r_state == WAIT) && aes_done;

`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_err;

  assign w_timeout = (r_state == WAIT) && !aes_done &&
                     (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else if ((r_state == WAIT) && !aes_done && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + TO_W'(1);
    end else begin
      r_wait_cnt <= '0;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_rd_cnt      <= '0;
      r_cap_cnt     <= '0;
      r_wr_cnt      <= '0;
      r_rd_d        <= 1'b0;
      r_aes_block   <= '0;
      r_aes_start   <= 1'b0;
      r_blocks_done <= '0;
    end else begin
      r_rd_d <= w_in_read;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_in_read) begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
          end
          // in_data is the registered FIFO output, valid the cycle after the read strobe.
          if (r_rd_d) begin
            r_aes_block[BLOCK_W-1-WORD_W*int'(r_cap_cnt) -: WORD_W] <= in_data;
            r_cap_cnt <= r_cap_cnt + 2'd1;
            if (r_cap_cnt == 2'd3) begin
              r_rd_cnt    <= '0;
              r_aes_start <= 1'b1;
              r_state     <= START;
            end
          end
        end
        START: begin
          r_aes_start <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            r_state <= DRAIN;
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (w_out_write) begin
            r_wr_cnt <= r_wr_cnt + 2'd1;
            if (r_wr_cnt == 2'd3) begin
              r_blocks_done <= r_blocks_done + CNT_W'(1);
              r_state       <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  aes_seq_word_unpack u_unpack (
    .clk    (clk),
    .resetn (resetn),
    .load   (w_load),
    .din    (aes_result),
    .sel    (r_wr_cnt),
    .dout   (out_data)
  );

  assign in_read     = w_in_read;
  assign out_write   = w_out_write;
  assign aes_block   = r_aes_block;
  assign aes_start   = r_aes_start;
  assign busy        = (r_state != IDLE);
  assign blocks_done = r_blocks_done;

endmodule

// File: doc/aes_fifo_sequencer.md
Name: aes_fifo_sequencer

Overview:
Moves 32-bit words between the input word FIFO, the AES-256 round core and the output word FIFO. Pops four words from the input FIFO and packs them into one 128-bit block, then pulses start to the AES core. On done it latches the result and pushes it as four words into the output FIFO. Sits between the bus-side FIFOs and the cipher core; it is the only agent driving the FIFO read/write strobes on the core side.

Parameters:
WORD_W, 32, FIFO word width; fixed, BLOCK_W/WORD_W must equal 4
BLOCK_W, 128, AES block width
CNT_W, 16, width of completed-block counter
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
enable  in  1  allows a new block to start (sampled in IDLE only)
in_empty  in  1  input FIFO empty flag
in_read  out  1  input FIFO read strobe; data valid on in_data the following cycle
in_data  in  WORD_W  input FIFO registered read data
aes_block  out  BLOCK_W  packed plaintext to AES core, stable from START until done
aes_start  out  1  one-cycle start pulse
aes_done  in  1  one-cycle completion pulse from AES core
aes_result  in  BLOCK_W  AES output, valid with aes_done
out_full  in  1  output FIFO full flag
out_write  out  1  output FIFO write strobe
out_data  out  WORD_W  word to output FIFO, valid with out_write
busy  out  1  high whenever state != IDLE
blocks_done  out  CNT_W  count of blocks fully drained, wraps at 2^CNT_W
err_timeout  out  1  sticky watchdog flag (constant 0 when feature disabled)

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE; in_read, aes_start, out_write, busy, err_timeout = 0; aes_block, out_data = 0; blocks_done=0; rd_cnt=cap_cnt=wr_cnt=0. Reset mid-operation abandons the block; partially read words are lost.
- States: IDLE -> FETCH -> START -> WAIT -> DRAIN -> IDLE.
- IDLE: if enable=1 go FETCH next cycle. No strobes.
- FETCH: in_read = (!in_empty && rd_cnt<4); rd_cnt increments on each in_read. Back-to-back reads allowed. The cycle after each in_read, in_data is captured: cap_cnt 0 -> aes_block[127:96], 1 -> [95:64], 2 -> [63:32], 3 -> [31:0]. After the 4th capture go START. in_empty rising mid-fetch simply stalls; no timeout.
- START: aes_start=1 for exactly this cycle; go WAIT.
- WAIT: on aes_done=1 latch aes_result into the result register, go DRAIN. aes_done in any other state is ignored.
- DRAIN: out_write = !out_full; out_data = result word wr_cnt (MSW first, same ordering as FETCH); wr_cnt increments on each write. After the 4th write: blocks_done+1, counters cleared, go IDLE. out_full stalls without losing data.
- Minimum latency: enable to first aes_start = 6 cycles with a non-empty FIFO (IDLE, 4 reads, last capture, START). Drain takes 4 cycles when never full.
- enable dropping after IDLE has no effect; the current block completes.
- Never asserts in_read when in_empty=1, nor out_write when out_full=1.

Optional Feature:
SEQ_TIMEOUT_EN: when defined, a cycle counter runs in WAIT. If TIMEOUT_CYCLES elapse without aes_done, err_timeout is set (sticky until reset), the block is discarded, and the state goes IDLE without blocks_done increment. When undefined, WAIT waits indefinitely, err_timeout is tied 0, and no counter is synthesised.

Decomposition:
- Package aes_seq_pkg: state encoding (IDLE, FETCH, START, WAIT, DRAIN), WORD_W, BLOCK_W, WORDS_PER_BLOCK=4, word-index slicing function.
- One sub-module, aes_seq_word_unpack: 128-bit holding register with load and a 2-bit word select, used for the DRAIN side; FETCH packing stays inline.

Test Plan:
- Preload input FIFO with 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; enable=1 -> aes_block=0x00112233_44556677_8899AABB_CCDDEEFF at aes_start, aes_start high exactly one cycle, 6 cycles after enable.
- AES model returns 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D 10 cycles after start -> four out_write pulses carrying DEADBEEF, 01234567, 89ABCDEF, CAFEF00D in order; blocks_done=1.
- Input FIFO holds 2 words, 3rd and 4th pushed 5 cycles later -> no in_read while in_empty=1; block assembled correctly.
- out_full held high for 8 cycles after the 2nd output word -> out_write low during stall; words 3 and 4 emitted unchanged afterwards.
- resetn low for one cycle during WAIT, then stray aes_done -> all outputs at reset values, state IDLE, stray done ignored, blocks_done=0.
- SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, no aes_done -> err_timeout=1 after 64 WAIT cycles, return to IDLE, blocks_done unchanged.
